// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a 2-entry {instr, pc} buffer.
// Optional macro FETCH_STALL_CNT_EN adds a saturating fetch_stall_cnt output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] fetch_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] fetch_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HALTED} state_t;

  state_t      state, state_next;
  logic [31:0] buf_instr [2];
  logic [31:0] buf_pc    [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_next;
  logic        ack_fire, push, pop;

  assign imem_req    = (state == REQ);
  assign imem_addr   = fetch_pc;
  assign ack_fire    = imem_req & imem_ack;
  assign push        = ack_fire & ~redirect_en;
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign instr_out   = instr_valid ? buf_instr[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : 32'h0;
  assign count_next  = count + {1'b0, push} - {1'b0, pop};

  // Redirect dominates everything; halt otherwise parks the requester while the buffer drains.
  always_comb begin
    state_next = state;
    if (redirect_en) begin
      state_next = halt ? HALTED : REQ;
    end else if (halt) begin
      state_next = HALTED;
    end else begin
      case (state)
        IDLE:    if (count != 2'd2) state_next = REQ;
        REQ:     if (ack_fire) state_next = (count_next != 2'd2) ? REQ : IDLE;
        HALTED:  state_next = (count != 2'd2) ? REQ : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else if (redirect_en) begin
      fetch_pc <= redirect_pc;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_instr[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]    <= fetch_pc;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || redirect_en)
      fetch_stall_cnt <= 16'h0;
    else if (imem_req && !imem_ack && fetch_stall_cnt != 16'hFFFF)
      fetch_stall_cnt <= fetch_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected {instr, pc} plus directed scenarios.
// Define FETCH_STALL_CNT_EN to also exercise the stall counter.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [31:0] fetch_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] fetch_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q [$];
  logic [31:0] model_pc;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_pc    (fetch_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0] ^ 16'hA5C3, ~addr[15:0]};
  endfunction

  assign imem_rdata = memWord(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, score the cycle against the model, advance to the next negedge.
  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                               input logic hlt, input logic ack, input logic rdy);
    logic [63:0] e;
    reset       = rst;
    redirect_en = redir;
    redirect_pc = rpc;
    halt        = hlt;
    imem_ack    = ack;
    instr_ready = rdy;
    #1;
    if (rst) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else begin
      checkOutput("fetch_pc", fetch_pc, model_pc);
      if (imem_req) checkOutput("imem_addr", imem_addr, model_pc);
      checkOutput("instr_valid", {31'h0, instr_valid}, {31'h0, exp_q.size() != 0});
      if (instr_valid && rdy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("instr_out", instr_out, e[63:32]);
        checkOutput("instr_pc", instr_pc, e[31:0]);
      end
      if (imem_req && ack && !redir) begin
        exp_q.push_back({memWord(model_pc), model_pc});
        model_pc = model_pc + 32'd4;
      end
      if (redir) begin
        exp_q.delete();
        model_pc = rpc;
      end
      checkOutput("depth_le_2", {31'h0, exp_q.size() <= 2}, 32'h1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitReq(input int budget, input logic ack, input logic rdy);
    int n = 0;
    while (!imem_req && n < budget) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, ack, rdy);
      n++;
    end
    checkOutput("req_wait", {31'h0, imem_req}, 32'h1);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] rpc;
    logic        rd, hl;
    reset = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0;
    halt = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    @(negedge clk);

    // Reset dominates redirect, halt and ack.
    doReset();
    doReset();
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rst_instr", instr_out, 32'h0);
    checkOutput("rst_ipc", instr_pc, 32'h0);
    checkOutput("rst_fpc", fetch_pc, RESET_PC);
    checkOutput("rst_addr", imem_addr, RESET_PC);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("rst_stall", {16'h0, fetch_stall_cnt}, 32'h0);
`endif

    // Streaming: ack and ready always high.
    waitReq(4, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("seq_addr", imem_addr, 32'(4 * i));
      if (i > 0) checkOutput("seq_ipc", instr_pc, 32'(4 * (i - 1)));
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    end

    // Consumer stalled: two pushes fill the buffer, then requests stop.
    doReset();
    waitReq(4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("full_req", {31'h0, imem_req}, 32'h0);
    checkOutput("full_ipc", instr_pc, 32'h0);
    checkOutput("full_fpc", fetch_pc, 32'h8);
    waitReq(6, 1'b1, 1'b1);
    checkOutput("resume_addr", imem_addr, 32'h8);

    // Redirect together with an ack drops the returned word.
    doReset();
    waitReq(4, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("pre_redir_addr", imem_addr, 32'h8);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1);
    checkOutput("redir_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("redir_req", {31'h0, imem_req}, 32'h1);
    checkOutput("redir_addr", imem_addr, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("redir_ipc", instr_pc, 32'h100);

    // Halt mid-request withdraws it while the buffer drains; release resumes at the same pc.
    doReset();
    waitReq(4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("halt_req", {31'h0, imem_req}, 32'h0);
    checkOutput("halt_drained", {31'h0, instr_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("halt_hold", {31'h0, imem_req}, 32'h0);
    checkOutput("halt_fpc", fetch_pc, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("unhalt_req", {31'h0, imem_req}, 32'h1);
    checkOutput("unhalt_addr", imem_addr, 32'h4);

    // Address wrap and stall counting.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("stall_clr", {16'h0, fetch_stall_cnt}, 32'h0);
`endif
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
`ifdef FETCH_STALL_CNT_EN
    checkOutput("stall_cnt", {16'h0, fetch_stall_cnt}, 32'h3);
`endif
    checkOutput("wrap_hold", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkOutput("wrap_ipc", instr_pc, 32'hFFFF_FFFC);

    // Random traffic scored entirely by the model.
    for (int i = 0; i < 200; i++) begin
      rd  = ($urandom_range(0, 15) == 0);
      hl  = ($urandom_range(0, 9) == 0);
      rpc = $urandom() & 32'hFFFF_FFFC;
      applyStimulus(1'b0, rd, rpc, hl, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("final_drain", {31'h0, instr_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
